// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel debouncer with rise/fall, long-press and held outputs
// Optional auto-repeat pulses are built when DEBOUNCE_REPEAT_EN is defined.
module debounce_bank #(
  parameter int CH         = 4,
  parameter int STABLE_CYC = 100000,
  parameter int LONG_CYC   = 100000000,
  parameter int REPEAT_CYC = 20000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] noisy,
  output logic [CH-1:0] level,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic [CH-1:0] long_press,
  output logic [CH-1:0] held,
  output logic [CH-1:0] repeat_p
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYC - 1);
`ifdef DEBOUNCE_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC + 1);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYC - 1);
`endif

  if (CH < 1 || STABLE_CYC < 1 || LONG_CYC < 2 || REPEAT_CYC < 1) begin : g_bad_params
    $error("debounce_bank: parameter out of range");
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          lp_q, lp_d;
    logic          held_q, held_d;

    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == STABLE_LAST) begin
        cnt_d   = '0;
        level_d = sync_q[1];
        rise_d  = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      // An accepted release takes priority over a long-press reaching its terminal count.
      hcnt_d = hcnt_q;
      held_d = held_q;
      lp_d   = 1'b0;
      if (!level_q || fall_d) begin
        hcnt_d = '0;
        held_d = 1'b0;
      end else if (hcnt_q == LONG_LAST) begin
        if (!held_q) begin
          lp_d   = 1'b1;
          held_d = 1'b1;
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        hcnt_q  <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        lp_q    <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], noisy[g]};
        cnt_q   <= cnt_d;
        hcnt_q  <= hcnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        lp_q    <= lp_d;
        held_q  <= held_d;
      end
    end

    assign level[g]      = level_q;
    assign rise[g]       = rise_q;
    assign fall[g]       = fall_q;
    assign long_press[g] = lp_q;
    assign held[g]       = held_q;

`ifdef DEBOUNCE_REPEAT_EN
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rep_q, rep_d;

    always_comb begin
      rcnt_d = rcnt_q;
      rep_d  = 1'b0;
      if (fall_d || lp_d) begin
        rcnt_d = '0;
      end else if (held_q) begin
        if (rcnt_q == REPEAT_LAST) begin
          rep_d  = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rcnt_q <= '0;
        rep_q  <= 1'b0;
      end else begin
        rcnt_q <= rcnt_d;
        rep_q  <= rep_d;
      end
    end

    assign repeat_p[g] = rep_q;
`else
    assign repeat_p[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - scoreboard bench for debounce_bank against a window/timer reference model
module tb_debounce_bank;

  localparam int CH = 2;
  localparam int ST = 8;
  localparam int LG = 32;
  localparam int RP = 10;
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] lp;
    logic [CH-1:0] held;
    logic [CH-1:0] rep;
  } out_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH-1:0] noisy = '0;
  logic [CH-1:0] level, rise, fall, long_press, held, repeat_p;

  int checks = 0;
  int errors = 0;

  out_t exp_q[$];

  debounce_bank #(
    .CH(CH), .STABLE_CYC(ST), .LONG_CYC(LG), .REPEAT_CYC(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .noisy(noisy),
    .level(level), .rise(rise), .fall(fall),
    .long_press(long_press), .held(held), .repeat_p(repeat_p)
  );

  always #5 clk = ~clk;

  function automatic out_t dut_out();
    return {level, rise, fall, long_press, held, repeat_p};
  endfunction

  // Reference model: a level is accepted once the last ST synchronised samples all
  // disagree with it; long-press/held/repeat follow from the time since the rise.
  int hist[CH][ST+2];
  bit m_level[CH];
  int t_high[CH];

  always @(posedge clk) begin : model
    out_t e;
    bit   lvl;
    bit   accept;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      if (!rst_n) begin
        for (int i = 0; i < ST + 2; i++) hist[c][i] = 0;
        m_level[c] = 1'b0;
        t_high[c]  = 0;
      end else begin
        lvl = m_level[c];
        for (int i = ST + 1; i > 0; i--) hist[c][i] = hist[c][i-1];
        hist[c][0] = int'(noisy[c]);
        accept = 1'b1;
        for (int i = 2; i <= ST + 1; i++) if (hist[c][i] == int'(lvl)) accept = 1'b0;
        if (accept) begin
          m_level[c] = ~lvl;
          t_high[c]  = 0;
          if (!lvl) e.rise[c] = 1'b1;
          else      e.fall[c] = 1'b1;
        end else if (lvl) begin
          t_high[c]++;
          if (t_high[c] == LG) e.lp[c] = 1'b1;
          if (REP_EN && t_high[c] > LG && (t_high[c] - LG) % RP == 0) e.rep[c] = 1'b1;
        end
        e.level[c] = m_level[c];
        e.held[c]  = m_level[c] && t_high[c] >= LG;
      end
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    out_t a;
    out_t e;
    a = dut_out();
    if (!rst_n) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      checks++;
      if (a !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h expected 0 at %0t", a, $time);
      end
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs: got lvl=%b rise=%b fall=%b lp=%b held=%b rep=%b expected lvl=%b rise=%b fall=%b lp=%b held=%b rep=%b at %0t",
                 a.level, a.rise, a.fall, a.lp, a.held, a.rep,
                 e.level, e.rise, e.fall, e.lp, e.held, e.rep, $time);
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (dut_out() !== '0) begin
      errors++;
      $display("FAIL %s: got %h expected 0 at %0t", name, dut_out(), $time);
    end
  endtask

  task automatic drive(input logic [CH-1:0] v, input int n);
    noisy = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered 1 time unit after a rising edge; asserts reset mid-cycle.
  task automatic do_reset(input int n);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int cycles);
    int            remain[CH];
    int            r;
    logic [CH-1:0] v;
    v = noisy;
    for (int c = 0; c < CH; c++) remain[c] = 0;
    for (int n = 0; n < cycles; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (remain[c] == 0) begin
          r    = int'($urandom_range(0, 9));
          v[c] = ~v[c];
          if (r < 5)      remain[c] = int'($urandom_range(1, 9));
          else if (r < 8) remain[c] = int'($urandom_range(7, 16));
          else            remain[c] = int'($urandom_range(30, 70));
        end
        remain[c]--;
      end
      noisy = v;
      if ($urandom_range(0, 599) == 0) begin
        do_reset(int'($urandom_range(2, 4)));
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_state");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(2'b00, 5);

    // clean press held long enough for long-press and repeats, then release
    drive(2'b01, 90);
    drive(2'b00, 20);

    // bounce every 3 cycles, then settle high
    for (int i = 0; i < 10; i++) drive((i % 2 == 0) ? 2'b01 : 2'b00, 3);
    drive(2'b01, 20);

    // 7-cycle low glitch rejected, 12-cycle low accepted
    drive(2'b00, 7);
    drive(2'b01, 5);
    drive(2'b00, 12);

    // release accepted exactly when long-press would fire, and one cycle later
    drive(2'b01, LG);
    drive(2'b00, 15);
    drive(2'b01, LG + 1);
    drive(2'b00, 15);

    // both channels together
    drive(2'b11, 60);
    drive(2'b00, 15);

    // reset mid-count, released with input high
    drive(2'b01, 6);
    do_reset(3);
    drive(2'b01, 60);
    // reset while held
    do_reset(2);
    drive(2'b01, 50);
    drive(2'b00, 15);

    random_phase(3000);

    drive(2'b00, 20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
